vga_fetch_sched: RTL and testbench
==================================

VGA_FETCH_SCHED -- requirements
Module: vga_fetch_sched

Interface
REQ-001 Parameter HDISP, default 800: active pixels per line.
REQ-002 Parameter VDISP, default 480: active lines per frame.
REQ-003 Parameter BURST, default 16: pixels per read burst; HDISP*VDISP SHALL be a multiple of BURST (elaboration-time check).
REQ-004 Parameter FIFO_DEPTH, default 256: pixel FIFO depth; SHALL be >= 2*BURST.
REQ-005 Parameter ADDR_W, default 32: byte-address width; 4 bytes per pixel.
REQ-006 pixel_clk  in  1  clock; all logic posedge.
REQ-007 pixel_rst  in  1  reset, asynchronous, active-high.
REQ-008 enable  in  1  fetching allowed; sampled every cycle.
REQ-009 frame_base  in  ADDR_W  framebuffer base byte address; latched at frame start.
REQ-010 vs  in  1  vertical sync from timing generator, active-low.
REQ-011 blank  in  1  timing-generator display flag, 1 = active pixel.
REQ-012 fifo_level  in  clog2(FIFO_DEPTH+1)  pixels currently in FIFO.
REQ-013 rd_req  out  1  burst read request.
REQ-014 rd_addr  out  ADDR_W  burst start byte address.
REQ-015 rd_ack  in  1  request accepted.
REQ-016 rd_done  in  1  single-cycle pulse, last pixel of burst written to FIFO.
REQ-017 fifo_flush  out  1  single-cycle pulse, clears FIFO.
REQ-018 frame_start  out  1  single-cycle pulse, coincident with fifo_flush.
REQ-019 underflow  out  1  sticky underflow flag.
REQ-020 underflow_clr  in  1  clears underflow.
REQ-021 busy  out  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have states IDLE, ARM, CHECK, REQ and XFER.
REQ-023 IDLE -> ARM when enable=1; any state -> IDLE when enable=0, except REQ/XFER, which SHALL first complete the burst (rd_done).
REQ-024 The frame trigger SHALL be the falling edge of vs (registered vs=1, current vs=0).
REQ-025 ARM -> CHECK on the trigger: same cycle fifo_flush=1, frame_start=1, base latched from frame_base, pixel counter cleared.
REQ-026 CHECK -> REQ when fifo_level+BURST <= FIFO_DEPTH and pixel counter < HDISP*VDISP; CHECK -> ARM when counter = HDISP*VDISP.
REQ-027 rd_addr SHALL equal base + 4*pixel_counter, computed modulo 2^ADDR_W, stable while rd_req=1.
REQ-028 REQ: rd_req=1 until rd_ack sampled 1; rd_req SHALL be 0 from the cycle after ack; next state XFER.
REQ-029 XFER: on rd_done, pixel counter += BURST and next state CHECK; rd_done in the same cycle as rd_ack SHALL complete the burst directly (REQ -> CHECK).
REQ-030 At most one burst SHALL be outstanding.
REQ-031 A vs trigger in CHECK SHALL restart the frame as in REQ-025; in REQ/XFER it SHALL set restart_pending, applied (flush, frame_start, relatch) on the rd_done cycle; in IDLE it SHALL be ignored.
REQ-032 underflow SHALL set the cycle after blank=1 with fifo_level=0, while busy=1.
REQ-033 underflow_clr SHALL clear underflow; simultaneous set and clear SHALL leave it set.
REQ-034 rd_ack or rd_done outside REQ/XFER SHALL be ignored.

Reset
REQ-035 On pixel_rst: state IDLE, rd_req=0, rd_addr=0, fifo_flush=0, frame_start=0, underflow=0, busy=0, pixel counter=0, restart_pending=0, registered vs=1.
REQ-036 Reset mid-burst SHALL abandon the burst; no completion is awaited.

Structure
REQ-037 Package vga_pkg SHALL hold the FSM state enum, BYTES_PER_PIXEL=4 and the default timing constants (HDISP/VDISP/porch/pulse values) shared with the timing generator.
REQ-038 One sub-module, vga_edge_det (registered falling-edge detector with reset value 1), SHALL produce the vs trigger.

Verification
REQ-039 Reset then enable=1, vs 1->0, fifo_level=0, frame_base=0x1000_0000 -> fifo_flush/frame_start pulse; rd_req=1, rd_addr=0x1000_0000 in CHECK+1.
REQ-040 ack after 3 cycles, done after 16 -> next rd_addr=0x1000_0040; full frame yields exactly 24000 bursts, then ARM.
REQ-041 fifo_level=241 (BURST=16, depth 256) -> no rd_req; level 240 -> rd_req next cycle.
REQ-042 vs falls during XFER -> no flush until rd_done; flush on rd_done cycle; next rd_addr = new base.
REQ-043 blank=1 with fifo_level=0 -> underflow=1 next cycle; underflow_clr and set together -> stays 1; clr alone -> 0.
REQ-044 pixel_rst asserted while rd_req=1 -> all outputs at reset values immediately; asynchronous.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions for the fetch scheduler and the timing generator.
// Holds the scheduler state encoding, the framebuffer pixel size and the
// default 800x480 display timing.
package vga_pkg;

  // Framebuffer pixels are 32-bit words.
  localparam int BYTES_PER_PIXEL = 4;

  // Default 800x480 timing, in pixel clocks and lines.
  localparam int H_DISP  = 800;
  localparam int H_FRONT = 40;
  localparam int H_SYNC  = 48;
  localparam int H_BACK  = 88;
  localparam int V_DISP  = 480;
  localparam int V_FRONT = 13;
  localparam int V_SYNC  = 3;
  localparam int V_BACK  = 32;

  // Default fetch geometry.
  localparam int DEF_BURST      = 16;
  localparam int DEF_FIFO_DEPTH = 256;

  // Fetch scheduler states.
  //   IDLE  : fetching disabled
  //   ARM   : waiting for the start of a frame
  //   CHECK : deciding whether the next burst fits / the frame is done
  //   REQ   : read request presented, waiting for acceptance
  //   XFER  : burst accepted, waiting for its last pixel
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    XFER  = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/vga_fetch_sched_if.sv
// Burst read bus between the fetch scheduler (master) and the memory read
// engine (slave).
//   rd_req  : burst read request, held until accepted
//   rd_addr : burst start byte address, stable while rd_req=1
//   rd_ack  : request accepted
//   rd_done : one-cycle pulse, last pixel of the burst written to the FIFO
interface vga_fetch_sched_if #(
  parameter int ADDR_W = 32
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_done;

  modport master (
    output rd_req,
    output rd_addr,
    input  rd_ack,
    input  rd_done
  );

  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_ack,
    output rd_done
  );

endinterface

// File: rtl/vga_edge_det.sv
// Registered falling-edge detector.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   d    : input level
//   fall : high while the registered level is 1 and the current level is 0
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);

  logic d_q;

  // Resetting to 1 means a line that is already low when reset releases
  // produces a trigger on the first cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b1;
    end else begin
      d_q <= d;
    end
  end

  assign fall = d_q & ~d;

endmodule

// File: rtl/vga_fetch_sched.sv
// Framebuffer fetch scheduler: issues one burst read at a time to keep the
// pixel FIFO topped up, restarting from the frame base at each falling edge
// of vs, and flags FIFO underflow during active display.
//   pixel_clk, pixel_rst : clock, asynchronous active-high reset
//   enable               : fetching allowed
//   frame_base           : framebuffer base byte address, latched per frame
//   vs                   : vertical sync, active-low (falling edge = new frame)
//   blank                : 1 = active pixel being displayed
//   fifo_level           : pixels currently in the FIFO
//   rd                   : burst read bus (master side)
//   fifo_flush           : one-cycle FIFO clear at frame start
//   frame_start          : one-cycle pulse coincident with fifo_flush
//   underflow            : sticky underflow flag
//   underflow_clr        : clears underflow
//   busy                 : scheduler is not IDLE
module vga_fetch_sched
  import vga_pkg::*;
#(
  parameter int HDISP      = H_DISP,
  parameter int VDISP      = V_DISP,
  parameter int BURST      = DEF_BURST,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int ADDR_W     = 32
) (
  input  logic                               pixel_clk,
  input  logic                               pixel_rst,
  input  logic                               enable,
  input  logic [ADDR_W-1:0]                  frame_base,
  input  logic                               vs,
  input  logic                               blank,
  input  logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  vga_fetch_sched_if.master                  rd,
  output logic                               fifo_flush,
  output logic                               frame_start,
  output logic                               underflow,
  input  logic                               underflow_clr,
  output logic                               busy
);

  localparam int TOTAL = HDISP * VDISP;
  localparam int CNT_W = $clog2(TOTAL + 1);

  if ((TOTAL % BURST) != 0) begin : g_bad_burst
    $error("vga_fetch_sched: HDISP*VDISP must be a multiple of BURST");
  end
  if (FIFO_DEPTH < 2 * BURST) begin : g_bad_depth
    $error("vga_fetch_sched: FIFO_DEPTH must be at least 2*BURST");
  end

  fetch_state_t      state;
  logic [CNT_W-1:0]  pix_cnt;
  logic [ADDR_W-1:0] base;
  logic              restart_pending;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;

  logic vs_fall;
  logic room;
  logic frame_done;
  logic burst_end;
  logic do_restart;

  vga_edge_det u_vs_edge (
    .clk  (pixel_clk),
    .rst  (pixel_rst),
    .d    (vs),
    .fall (vs_fall)
  );

  // A whole burst must fit in the free FIFO space before it is requested.
  assign room       = (32'(fifo_level) + 32'(BURST)) <= 32'(FIFO_DEPTH);
  assign frame_done = (pix_cnt == CNT_W'(TOTAL));

  // A burst ends on rd_done in XFER, or on rd_done arriving together with
  // rd_ack in REQ. rd_ack/rd_done in any other state are ignored.
  assign burst_end = rd.rd_done && ((state == XFER) || (state == REQ && rd.rd_ack));

  // Frame restart: immediate in ARM/CHECK, deferred to the end of the
  // outstanding burst in REQ/XFER (including a vs edge on that very cycle).
  assign do_restart = enable && (
                        (vs_fall && (state == ARM || state == CHECK)) ||
                        (burst_end && (restart_pending || vs_fall)));

  // NOTE: every register here has an asynchronous reset; the sensitivity list
  // carries the reset edge so outputs return to their idle values without a
  // clock, which abandons any burst in flight.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      rd_req_q        <= 1'b0;
      rd_addr_q       <= '0;
      fifo_flush      <= 1'b0;
      frame_start     <= 1'b0;
      pix_cnt         <= '0;
      base            <= '0;
      restart_pending <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so a later assignment in
      // this block overrides an earlier default within the same cycle.
      fifo_flush  <= 1'b0;
      frame_start <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            state <= CHECK;
          end
        end

        CHECK: begin
          if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            state <= CHECK;
          end else if (frame_done) begin
            state <= ARM;
          end else if (room) begin
            state     <= REQ;
            rd_req_q  <= 1'b1;
            rd_addr_q <= base + ADDR_W'(pix_cnt) * ADDR_W'(BYTES_PER_PIXEL);
          end
        end

        REQ, XFER: begin
          if (state == REQ && rd.rd_ack) begin
            rd_req_q <= 1'b0;
            state    <= XFER;
          end
          if (burst_end) begin
            restart_pending <= 1'b0;
            pix_cnt         <= pix_cnt + CNT_W'(BURST);
            if (enable) begin
              state <= CHECK;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else if (vs_fall) begin
            restart_pending <= 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          rd_req_q <= 1'b0;
        end
      endcase

      // Frame (re)start overrides the counter update above.
      if (do_restart) begin
        fifo_flush  <= 1'b1;
        frame_start <= 1'b1;
        base        <= frame_base;
        pix_cnt     <= '0;
      end
    end
  end

  // Set wins over clear so an underflow seen on the clearing cycle is kept.
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      underflow <= 1'b0;
    end else if (blank && fifo_level == '0 && busy) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

  assign rd.rd_req  = rd_req_q;
  assign rd.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_vga_fetch_sched.sv
// Self-checking bench for vga_fetch_sched with a small 64x2 frame
// (8 bursts of 16 pixels) so full frames stay short.
module tb_vga_fetch_sched;

  localparam int HDISP      = 64;
  localparam int VDISP      = 2;
  localparam int BURST      = 16;
  localparam int FIFO_DEPTH = 256;
  localparam int ADDR_W     = 32;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int NBURSTS    = (HDISP * VDISP) / BURST;

  logic              pixel_clk = 1'b0;
  logic              pixel_rst;
  logic              enable;
  logic [ADDR_W-1:0] frame_base;
  logic              vs;
  logic              blank;
  logic [LVL_W-1:0]  fifo_level;
  logic              fifo_flush;
  logic              frame_start;
  logic              underflow;
  logic              underflow_clr;
  logic              busy;

  vga_fetch_sched_if #(.ADDR_W(ADDR_W)) rd_if ();

  vga_fetch_sched #(
    .HDISP      (HDISP),
    .VDISP      (VDISP),
    .BURST      (BURST),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .pixel_clk     (pixel_clk),
    .pixel_rst     (pixel_rst),
    .enable        (enable),
    .frame_base    (frame_base),
    .vs            (vs),
    .blank         (blank),
    .fifo_level    (fifo_level),
    .rd            (rd_if),
    .fifo_flush    (fifo_flush),
    .frame_start   (frame_start),
    .underflow     (underflow),
    .underflow_clr (underflow_clr),
    .busy          (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_tests  = 0;
  int n_fail   = 0;
  int req_seen = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Wait for rd_req with a cycle budget; an expired budget is a failure.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (!rd_if.rd_req && n < 100) begin
      tick();
      n++;
    end
    check({name, "_req_timeout"}, 64'(rd_if.rd_req), 64'd1);
  endtask

  // Ack after ack_dly cycles of rd_req, done done_dly cycles after the ack.
  task automatic serve(input string name, input int ack_dly, input int done_dly);
    wait_req(name);
    repeat (ack_dly - 1) tick();
    rd_if.rd_ack = 1'b1;
    tick();
    rd_if.rd_ack = 1'b0;
    check({name, "_req_drop"}, 64'(rd_if.rd_req), 64'd0);
    repeat (done_dly - 1) tick();
    rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_done = 1'b0;
  endtask

  // Monitor: every new request pops the next expected address.
  logic req_prev = 1'b0;
  always @(negedge pixel_clk) begin
    if (pixel_rst) begin
      req_prev = 1'b0;
    end else begin
      if (rd_if.rd_req && !req_prev) begin
        req_seen++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_req: got addr %h, expected no request", rd_if.rd_addr);
        end else begin
          check("rd_addr", 64'(rd_if.rd_addr), 64'(exp_q.pop_front()));
        end
      end
      req_prev = rd_if.rd_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pixel_rst      = 1'b1;
    enable         = 1'b0;
    frame_base     = '0;
    vs             = 1'b1;
    blank          = 1'b0;
    fifo_level     = '0;
    underflow_clr  = 1'b0;
    rd_if.rd_ack   = 1'b0;
    rd_if.rd_done  = 1'b0;
    repeat (3) @(negedge pixel_clk);
    check("rst_rd_req", 64'(rd_if.rd_req), 64'd0);
    check("rst_rd_addr", 64'(rd_if.rd_addr), 64'd0);
    check("rst_flush", 64'(fifo_flush), 64'd0);
    check("rst_frame_start", 64'(frame_start), 64'd0);
    check("rst_underflow", 64'(underflow), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    pixel_rst = 1'b0;
    tick();

    // Frame 1: full frame at base 0x1000_0000, ack after 3, done after 16.
    enable = 1'b1;
    tick();
    check("arm_busy", 64'(busy), 64'd1);
    for (int k = 0; k < NBURSTS; k++) exp_q.push_back(32'h1000_0000 + 32'(k * 64));
    frame_base = 32'h1000_0000;
    vs = 1'b0;
    tick();
    check("f1_flush", 64'(fifo_flush), 64'd1);
    check("f1_frame_start", 64'(frame_start), 64'd1);
    tick();
    check("f1_flush_pulse", 64'(fifo_flush), 64'd0);
    check("f1_req_check_plus1", 64'(rd_if.rd_req), 64'd1);
    for (int k = 0; k < NBURSTS; k++) serve("f1", 3, 16);
    repeat (6) tick();
    check("f1_end_no_req", 64'(rd_if.rd_req), 64'd0);
    check("f1_end_busy", 64'(busy), 64'd1);
    check("f1_burst_count", 64'(req_seen), 64'(NBURSTS));

    // Underflow: set, set+clear together, clear alone.
    blank = 1'b1;
    tick();
    check("uf_set", 64'(underflow), 64'd1);
    underflow_clr = 1'b1;
    tick();
    check("uf_set_and_clr", 64'(underflow), 64'd1);
    blank = 1'b0;
    tick();
    check("uf_clr", 64'(underflow), 64'd0);
    underflow_clr = 1'b0;

    // Frame 2: FIFO too full at 241, request once it drops to 240.
    vs = 1'b1;
    fifo_level = LVL_W'(241);
    frame_base = 32'h2000_0000;
    tick();
    vs = 1'b0;
    tick();
    check("f2_flush", 64'(fifo_flush), 64'd1);
    repeat (5) tick();
    check("f2_level241_no_req", 64'(rd_if.rd_req), 64'd0);
    exp_q.push_back(32'h2000_0000);
    fifo_level = LVL_W'(240);
    tick();
    check("f2_level240_req", 64'(rd_if.rd_req), 64'd1);
    vs = 1'b1;
    serve("f2b0", 1, 2);

    // Ack and done on the same cycle complete the burst.
    exp_q.push_back(32'h2000_0040);
    wait_req("f2b1");
    rd_if.rd_ack  = 1'b1;
    rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_ack  = 1'b0;
    rd_if.rd_done = 1'b0;
    check("f2b1_req_drop", 64'(rd_if.rd_req), 64'd0);

    // vs falls during XFER: flush deferred to the rd_done cycle.
    exp_q.push_back(32'h2000_0080);
    wait_req("f2b2");
    rd_if.rd_ack = 1'b1;
    tick();
    rd_if.rd_ack = 1'b0;
    frame_base = 32'h3000_0000;
    vs = 1'b0;
    tick();
    check("xfer_no_flush_a", 64'(fifo_flush), 64'd0);
    tick();
    check("xfer_no_flush_b", 64'(fifo_flush), 64'd0);
    exp_q.push_back(32'h3000_0000);
    rd_if.rd_done = 1'b1;
    tick();
    rd_if.rd_done = 1'b0;
    check("done_flush", 64'(fifo_flush), 64'd1);
    check("done_frame_start", 64'(frame_start), 64'd1);
    serve("f3b0", 2, 3);

    // Reset while rd_req=1: outputs clear without a clock edge.
    exp_q.push_back(32'h3000_0040);
    wait_req("f3b1");
    @(negedge pixel_clk);
    #2;
    pixel_rst = 1'b1;
    #1;
    check("arst_rd_req", 64'(rd_if.rd_req), 64'd0);
    check("arst_rd_addr", 64'(rd_if.rd_addr), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_flush", 64'(fifo_flush), 64'd0);
    check("arst_frame_start", 64'(frame_start), 64'd0);
    check("arst_underflow", 64'(underflow), 64'd0);
    check("total_bursts", 64'(req_seen), 64'(NBURSTS + 5));
    check("exp_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
